// File: rtl/alu_mdu.sv
// EX-stage execution unit: single-cycle registered ALU plus iterative unsigned MULTU/DIVU
// with HI/LO result registers and valid/ready handshakes on both sides.
module alu_mdu #(
    parameter int unsigned N     = 64,
    parameter int unsigned CNT_W = 7
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] alu_a,
    input  logic [N-1:0] alu_b,
    input  logic [3:0]   alu_control,
    input  logic [1:0]   md_op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] alu_y,
    output logic         zero,
    output logic         div_by_zero,
    output logic [N-1:0] hi,
    output logic [N-1:0] lo,
    output logic         busy
);
    localparam int unsigned      ALIGN    = N - 32;
    localparam logic [N-1:0]     MASK32   = N'({32{1'b1}});
    localparam logic [CNT_W-1:0] CNT32    = CNT_W'(31);
    localparam logic [CNT_W-1:0] CNTN     = CNT_W'(N - 1);
    localparam logic [1:0]       MD_MULTU = 2'b01;
    localparam logic [1:0]       MD_DIVU  = 2'b10;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             w64_q, w64_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     shift_q, shift_d;
    logic [2*N-1:0]   acc_q, acc_d;
    logic [N-1:0]     y_q, y_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;
    logic [N-1:0]     hi_q, hi_d;
    logic [N-1:0]     lo_q, lo_d;

    logic             accept_c;
    logic [N-1:0]     mask_c, a_m_c, b_m_c, a_al_c, b_al_c;
    logic [N-1:0]     alu_raw_c, alu_res_c;
    logic [CNT_W-1:0] cnt_init_c;
    logic [2*N-1:0]   mul_nx_c, div_nx_c, step_c;
    logic [N:0]       div_r_c;
    logic             div_ge_c;
    logic [N-1:0]     res_lo_c, res_hi_c;

    assign in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept_c    = in_valid && in_ready;
    assign out_valid   = (state_q == DONE);
    assign busy        = (state_q == RUN);
    assign alu_y       = y_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // Operand masking; iterative operands are left-aligned so the active bit is always [N-1]
    assign mask_c     = alu_control[3] ? {N{1'b1}} : MASK32;
    assign a_m_c      = alu_a & mask_c;
    assign b_m_c      = alu_b & mask_c;
    assign a_al_c     = alu_control[3] ? a_m_c : (a_m_c << ALIGN);
    assign b_al_c     = alu_control[3] ? b_m_c : (b_m_c << ALIGN);
    assign cnt_init_c = alu_control[3] ? CNTN : CNT32;

    always_comb begin
        alu_raw_c = '0;
        case (alu_control[2:0])
            3'b000:  alu_raw_c = a_m_c & b_m_c;
            3'b001:  alu_raw_c = a_m_c | b_m_c;
            3'b010:  alu_raw_c = a_m_c + b_m_c;
            3'b100:  alu_raw_c = a_m_c & ~b_m_c;
            3'b101:  alu_raw_c = a_m_c | ~b_m_c;
            3'b110:  alu_raw_c = a_m_c - b_m_c;
            3'b111:  alu_raw_c = N'(a_m_c < b_m_c);
            default: alu_raw_c = '0;
        endcase
    end
    assign alu_res_c = alu_raw_c & mask_c;

    // One MSB-first iteration: shift-add multiply or restoring divide
    assign mul_nx_c = {acc_q[2*N-2:0], 1'b0}
                    + (shift_q[N-1] ? {{N{1'b0}}, mcand_q} : {(2*N){1'b0}});
    assign div_r_c  = {acc_q[2*N-1:N], shift_q[N-1]};
    assign div_ge_c = (div_r_c >= {1'b0, mcand_q});
    assign div_nx_c = {(div_ge_c ? (div_r_c[N-1:0] - mcand_q) : div_r_c[N-1:0]),
                       acc_q[N-2:0], div_ge_c};
    assign step_c   = is_div_q ? div_nx_c : mul_nx_c;
    assign res_lo_c = (is_div_q || w64_q) ? step_c[N-1:0] : N'(step_c[31:0]);
    assign res_hi_c = (is_div_q || w64_q) ? step_c[2*N-1:N] : N'(step_c[63:32]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            w64_q    <= 1'b0;
            mcand_q  <= '0;
            shift_q  <= '0;
            acc_q    <= '0;
            y_q      <= '0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            w64_q    <= w64_d;
            mcand_q  <= mcand_d;
            shift_q  <= shift_d;
            acc_q    <= acc_d;
            y_q      <= y_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        w64_d    = w64_q;
        mcand_d  = mcand_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        y_d      = y_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        // Flush drops any in-flight work and also blocks a same-cycle accept
        if (flush) begin
            state_d = IDLE;
        end else begin
            if (state_q == RUN) begin
                acc_d   = step_c;
                shift_d = {shift_q[N-2:0], 1'b0};
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d = DONE;
                    hi_d    = res_hi_c;
                    lo_d    = res_lo_c;
                    y_d     = res_lo_c;
                    zero_d  = (res_lo_c == '0);
                end
            end else if ((state_q == DONE) && out_ready) begin
                state_d = IDLE;
            end
            if (accept_c) begin
                dbz_d = 1'b0;
                w64_d = alu_control[3];
                case (md_op)
                    MD_MULTU: begin
                        state_d  = RUN;
                        cnt_d    = cnt_init_c;
                        is_div_d = 1'b0;
                        mcand_d  = a_m_c;
                        shift_d  = b_al_c;
                        acc_d    = '0;
                    end
                    MD_DIVU: begin
                        if (b_m_c == '0) begin
                            state_d = DONE;
                            y_d     = mask_c;
                            lo_d    = mask_c;
                            hi_d    = a_m_c;
                            zero_d  = 1'b0;
                            dbz_d   = 1'b1;
                        end else begin
                            state_d  = RUN;
                            cnt_d    = cnt_init_c;
                            is_div_d = 1'b1;
                            mcand_d  = b_m_c;
                            shift_d  = a_al_c;
                            acc_d    = '0;
                        end
                    end
                    default: begin
                        state_d = DONE;
                        y_d     = alu_res_c;
                        zero_d  = (alu_res_c == '0);
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: expected results queued at accept, compared at each output transfer.
`timescale 1ns/1ps
module tb_alu_mdu;
    localparam int unsigned N = 64;

    typedef struct packed {
        logic [N-1:0] y;
        logic [N-1:0] hi;
        logic [N-1:0] lo;
        logic         dbz;
        logic         is_md;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] alu_a = '0;
    logic [N-1:0] alu_b = '0;
    logic [3:0]   alu_control = '0;
    logic [1:0]   md_op = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] alu_y;
    logic         zero;
    logic         div_by_zero;
    logic [N-1:0] hi;
    logic [N-1:0] lo;
    logic         busy;

    alu_mdu #(.N(64), .CNT_W(7)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .md_op(md_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_y(alu_y), .zero(zero), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo), .busy(busy)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_pass = 0;
    exp_t         sb_q[$];
    exp_t         mon_e;
    logic [N-1:0] m_hi = '0;
    logic [N-1:0] m_lo = '0;

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [3:0] ctrl, input logic [1:0] md,
                                   input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t         e;
        logic [N-1:0] m;
        logic [N-1:0] am;
        logic [N-1:0] bm;
        logic [N-1:0] r;
        logic [2*N-1:0] p;
        e  = '0;
        m  = ctrl[3] ? {N{1'b1}} : 64'h0000_0000_FFFF_FFFF;
        am = a & m;
        bm = b & m;
        if (md == 2'b01) begin
            p       = {{N{1'b0}}, am} * {{N{1'b0}}, bm};
            e.is_md = 1'b1;
            if (ctrl[3]) begin
                e.lo = p[N-1:0];
                e.hi = p[2*N-1:N];
            end else begin
                e.lo = {32'h0, p[31:0]};
                e.hi = {32'h0, p[63:32]};
            end
            e.y = e.lo;
        end else if (md == 2'b10) begin
            e.is_md = 1'b1;
            if (bm == '0) begin
                e.lo  = m;
                e.hi  = am;
                e.dbz = 1'b1;
            end else begin
                e.lo = am / bm;
                e.hi = am % bm;
            end
            e.y = e.lo;
        end else begin
            case (ctrl[2:0])
                3'b000:  r = am & bm;
                3'b001:  r = am | bm;
                3'b010:  r = am + bm;
                3'b011:  r = '0;
                3'b100:  r = am & ~bm;
                3'b101:  r = am | ~bm;
                3'b110:  r = am - bm;
                default: r = (am < bm) ? 64'd1 : 64'd0;
            endcase
            e.y = r & m;
        end
        return e;
    endfunction

    // Transfers are decided on the sampled negedge values; pop before push for same-cycle reload
    always @(negedge clk) begin
        if (!reset_n) begin
            sb_q.delete();
            m_hi = '0;
            m_lo = '0;
        end else if (flush) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                chk("sb_nonempty", N'(sb_q.size() != 0), N'(1));
                if (sb_q.size() != 0) begin
                    mon_e = sb_q.pop_front();
                    if (mon_e.is_md) begin
                        m_hi = mon_e.hi;
                        m_lo = mon_e.lo;
                    end
                    chk("sb_y", alu_y, mon_e.y);
                    chk("sb_zero", N'(zero), N'(mon_e.y == '0));
                    chk("sb_hi", hi, m_hi);
                    chk("sb_lo", lo, m_lo);
                    chk("sb_dbz", N'(div_by_zero), N'(mon_e.dbz));
                end
            end
            if (in_valid && in_ready)
                sb_q.push_back(model(alu_control, md_op, alu_a, alu_b));
        end
    end

    task automatic issue(input logic [3:0] ctrl, input logic [1:0] md,
                         input logic [N-1:0] a, input logic [N-1:0] b);
        bit ok;
        ok          = 1'b0;
        alu_control = ctrl;
        md_op       = md;
        alu_a       = a;
        alu_b       = b;
        in_valid    = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("accepted", N'(ok), N'(1));
    endtask

    task automatic drain();
        int i;
        i = 0;
        while ((sb_q.size() != 0 || out_valid) && i < 300) begin
            @(posedge clk);
            #2;
            i++;
        end
        chk("drain", N'(sb_q.size()), N'(0));
    endtask

    task automatic count_busy(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (busy && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        chk(tag, N'(n), N'(exp_cycles));
        chk({tag, "_valid"}, N'(out_valid), N'(1));
    endtask

    initial begin
        logic [N-1:0] y0, h0, l0, ra, rb;
        logic [3:0]   rc;
        logic [1:0]   rm;
        longint       t0;
        bit           seen;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", N'(out_valid), N'(0));
        chk("rst_busy", N'(busy), N'(0));
        chk("rst_y", alu_y, '0);
        chk("rst_hilo", hi | lo, '0);
        chk("rst_flags", N'({zero, div_by_zero}), N'(0));
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // N-bit add wraparound, latency 1
        issue(4'b1010, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        chk("add64_valid", N'(out_valid), N'(1));
        chk("add64_y", alu_y, '0);
        chk("add64_zero", N'(zero), N'(1));
        drain();

        issue(4'b0010, 2'b00, 64'h1_FFFF_FFFF, 64'd1);
        chk("add32_y", alu_y, '0);
        chk("add32_zero", N'(zero), N'(1));
        issue(4'b0111, 2'b00, 64'd5, 64'd7);
        chk("sltu_y", alu_y, 64'd1);
        drain();

        issue(4'b0000, 2'b01, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
        count_busy("mul32_busy", 32);
        drain();
        chk("mul32_lo", lo, 64'd1);
        chk("mul32_hi", hi, 64'hFFFF_FFFE);

        issue(4'b1000, 2'b10, 64'd100, 64'd7);
        count_busy("div64_busy", 64);
        drain();
        chk("div64_lo", lo, 64'd14);
        chk("div64_hi", hi, 64'd2);
        chk("div64_dbz", N'(div_by_zero), N'(0));

        issue(4'b0000, 2'b10, 64'd42, 64'd0);
        chk("dbz_valid", N'(out_valid), N'(1));
        chk("dbz_lo", lo, 64'hFFFF_FFFF);
        chk("dbz_hi", hi, 64'd42);
        chk("dbz_flag", N'(div_by_zero), N'(1));
        drain();

        // Backpressure then same-edge reload and a sustained ALU stream
        out_ready = 1'b0;
        issue(4'b1001, 2'b00, 64'h1234_5678_9ABC_DEF0, 64'h0F0F_0000_FFFF_0001);
        y0 = alu_y;
        h0 = hi;
        l0 = lo;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_y", alu_y, y0);
            chk("bp_hilo", hi ^ lo, h0 ^ l0);
            chk("bp_in_ready", N'(in_ready), N'(0));
            chk("bp_valid", N'(out_valid), N'(1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        t0 = $time;
        for (int i = 0; i < 8; i++) begin
            rc = 4'($urandom_range(0, 15));
            issue(rc, 2'b00, {$urandom, $urandom}, {$urandom, $urandom});
        end
        chk("stream_rate", N'(($time - t0) / 10), N'(8));
        drain();

        // Random mix of ALU/MULTU/DIVU in both widths
        for (int i = 0; i < 20; i++) begin
            rc = 4'($urandom_range(0, 15));
            rm = 2'($urandom_range(0, 3));
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) rb = '0;
            else if ($urandom_range(0, 2) == 0) rb = 64'($urandom_range(1, 1000));
            issue(rc, rm, ra, rb);
        end
        drain();

        // Async reset mid-MULTU
        issue(4'b1000, 2'b01, 64'hDEAD_BEEF_0000_1234, 64'h0000_0001_0000_0003);
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("mrst_valid", N'(out_valid), N'(0));
        chk("mrst_busy", N'(busy), N'(0));
        chk("mrst_y", alu_y, '0);
        chk("mrst_hi", hi, '0);
        chk("mrst_lo", lo, '0);
        chk("mrst_flags", N'({zero, div_by_zero}), N'(0));
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Flush mid-DIVU keeps the last committed hi/lo
        issue(4'b1000, 2'b10, 64'd1000, 64'd3);
        drain();
        chk("pre_flush_lo", lo, 64'd333);
        chk("pre_flush_hi", hi, 64'd1);
        issue(4'b1000, 2'b10, 64'hFFFF_0000_1234_5678, 64'd12345);
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_busy", N'(busy), N'(0));
        chk("flush_valid", N'(out_valid), N'(0));
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_out", N'(seen), N'(0));
        chk("flush_lo", lo, 64'd333);
        chk("flush_hi", hi, 64'd1);

        // Flush wins over a simultaneous accept
        alu_control = 4'b1010;
        md_op       = 2'b00;
        alu_a       = 64'd3;
        alu_b       = 64'd4;
        in_valid    = 1'b1;
        flush       = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_vs_accept", N'(out_valid), N'(0));
        issue(4'b1110, 2'b11, 64'd3, 64'd4);
        chk("post_flush_sub", alu_y, 64'hFFFF_FFFF_FFFF_FFFF);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
